// File: rtl/inert_serf.sv
// SPI serf standing in for the 6-axis inertial sensor: decodes 16-bit monarch frames,
// holds the start-up configuration registers and captures a yaw sample every ODR period.
module inert_serf #(
    parameter logic [15:0] ODR_PERIOD = 16'd4096,
    parameter logic [7:0]  WHO_AM_I   = 8'h6A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        INT,
    input  logic [15:0] yaw_smpl,
    output logic        armed
);

    typedef enum logic [1:0] {IDLE, CMD, DATA, COMMIT} state_t;

    state_t      state, next_state;
    logic        ss_meta, ss_sync;
    logic        sclk_meta, sclk_sync, sclk_prev;
    logic        mosi_meta, mosi_sync;
    logic        sclk_rise, sclk_fall;
    logic [15:0] rx;
    logic [15:0] tx;
    logic [4:0]  bit_cnt;
    logic        skip_fall;
    logic [6:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [7:0]  reg_0d, reg_11, reg_14;
    logic [15:0] yaw;
    logic [15:0] timer;
    logic        sample_pend;
    logic        int_q;
    logic        frame_start, cmd_done, do_write, do_clr_int;
    logic        term_cnt, capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_meta   <= 1'b1;
            ss_sync   <= 1'b1;
            sclk_meta <= 1'b1;
            sclk_sync <= 1'b1;
            sclk_prev <= 1'b1;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
        end else begin
            ss_meta   <= SS_n;
            ss_sync   <= ss_meta;
            sclk_meta <= SCLK;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            mosi_meta <= MOSI;
            mosi_sync <= mosi_meta;
        end
    end

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign sclk_fall = ~sclk_sync & sclk_prev;

    // On the 8th rise the address LSB is still on mosi_sync, not yet in rx.
    assign rd_addr = {rx[5:0], mosi_sync};

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            7'h0D:   rd_data = reg_0d;
            7'h0F:   rd_data = WHO_AM_I;
            7'h11:   rd_data = reg_11;
            7'h14:   rd_data = reg_14;
            7'h26:   rd_data = yaw[7:0];
            7'h27:   rd_data = yaw[15:8];
            default: rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // After exactly 16 rises rx holds the whole frame, so COMMIT decodes it directly.
    always_comb begin
        next_state  = state;
        frame_start = 1'b0;
        cmd_done    = 1'b0;
        do_write    = 1'b0;
        do_clr_int  = 1'b0;
        case (state)
            IDLE: begin
                if (!ss_sync) begin
                    next_state  = CMD;
                    frame_start = 1'b1;
                end
            end
            CMD: begin
                if (ss_sync) begin
                    next_state = COMMIT;
                end else if (sclk_rise && bit_cnt == 5'd7) begin
                    next_state = DATA;
                    cmd_done   = 1'b1;
                end
            end
            DATA: begin
                if (ss_sync) next_state = COMMIT;
            end
            COMMIT: begin
                next_state = IDLE;
                if (bit_cnt == 5'd16) begin
                    do_write   = ~rx[15];
                    do_clr_int = rx[15] && (rx[14:8] == 7'h27);
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The fall following a tx load is not shifted, so the loaded MSB is what the monarch samples next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx        <= 16'h0000;
            tx        <= 16'h0000;
            bit_cnt   <= 5'd0;
            skip_fall <= 1'b0;
        end else if (frame_start) begin
            tx        <= 16'h0000;
            bit_cnt   <= 5'd0;
            skip_fall <= 1'b1;
        end else if (state == CMD || state == DATA) begin
            if (sclk_rise) begin
                rx <= {rx[14:0], mosi_sync};
                if (bit_cnt != 5'd31) bit_cnt <= bit_cnt + 5'd1;
            end
            if (cmd_done) begin
                tx        <= {rd_data, 8'h00};
                skip_fall <= 1'b1;
            end else if (sclk_fall) begin
                if (skip_fall) skip_fall <= 1'b0;
                else           tx        <= {tx[14:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_0d <= 8'h00;
            reg_11 <= 8'h00;
            reg_14 <= 8'h00;
        end else if (do_write) begin
            case (rx[14:8])
                7'h0D:   reg_0d <= rx[7:0];
                7'h11:   reg_11 <= rx[7:0];
                7'h14:   reg_14 <= rx[7:0];
                default: ;
            endcase
        end
    end

    assign armed    = (reg_0d == 8'h02) && (reg_11 == 8'h60);
    assign term_cnt = armed && (timer == ODR_PERIOD - 16'd1);
    // Capture waits for IDLE so yaw bytes never change under a frame in flight.
    assign capture  = sample_pend && (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer       <= 16'h0000;
            sample_pend <= 1'b0;
            yaw         <= 16'h0000;
            int_q       <= 1'b0;
        end else begin
            if (!armed || term_cnt) timer <= 16'h0000;
            else                    timer <= timer + 16'd1;

            if (term_cnt)     sample_pend <= 1'b1;
            else if (capture) sample_pend <= 1'b0;

            if (capture) begin
                yaw   <= yaw_smpl;
                int_q <= 1'b1;
            end else if (do_clr_int) begin
                int_q <= 1'b0;
            end
        end
    end

    assign MISO = tx[15] & ~ss_sync;
    assign INT  = int_q;

endmodule
